// File: rtl/leaf_router_pkg.sv
// Shared constants, arbiter state encoding and address decode for the leaf router.
package leaf_router_pkg;

  localparam int unsigned ADDR_W = 6;
  localparam logic [2:0] GRANT_NONE = 3'b111;

  typedef enum logic [0:0] {
    StIdle,
    StHold
  } arb_state_e;

  function automatic logic is_local_addr(input logic [ADDR_W-1:0] addr,
                                         input logic [3:0] group_id,
                                         input logic [1:0] router_id);
    return (addr[5:2] == group_id) && (addr[1:0] == router_id);
  endfunction

endpackage

// File: rtl/param_leaf_router_if.sv
// GPU and spine ingress/egress handshake bundle of the leaf router.
interface param_leaf_router_if #(
  parameter int unsigned N_SPINE = 4,
  parameter int unsigned DWIDTH  = 16
) ();

  localparam int unsigned AW = leaf_router_pkg::ADDR_W;

  logic [DWIDTH-1:0]         gpu_in_data;
  logic                      gpu_in_valid;
  logic [AW-1:0]             gpu_dest_addr;
  logic                      gpu_in_ready;
  logic [DWIDTH-1:0]         gpu_out_data;
  logic                      gpu_out_valid;
  logic                      gpu_out_ready;
  logic [N_SPINE*DWIDTH-1:0] spine_in_data;
  logic [N_SPINE-1:0]        spine_in_valid;
  logic [N_SPINE*AW-1:0]     spine_dest_addr;
  logic [N_SPINE-1:0]        spine_in_ready;
  logic [N_SPINE*DWIDTH-1:0] spine_out_data;
  logic [N_SPINE*AW-1:0]     spine_out_dest_addr;
  logic [N_SPINE-1:0]        spine_out_valid;
  logic [N_SPINE-1:0]        spine_out_ready;

  modport router (
    input  gpu_in_data, gpu_in_valid, gpu_dest_addr, gpu_out_ready,
    input  spine_in_data, spine_in_valid, spine_dest_addr, spine_out_ready,
    output gpu_in_ready, gpu_out_data, gpu_out_valid,
    output spine_in_ready, spine_out_data, spine_out_dest_addr, spine_out_valid
  );

  modport env (
    output gpu_in_data, gpu_in_valid, gpu_dest_addr, gpu_out_ready,
    output spine_in_data, spine_in_valid, spine_dest_addr, spine_out_ready,
    input  gpu_in_ready, gpu_out_data, gpu_out_valid,
    input  spine_in_ready, spine_out_data, spine_out_dest_addr, spine_out_valid
  );

endinterface

// File: rtl/router_fifo.sv
// Ingress FIFO: ready depends only on registered occupancy, never on the same-cycle pop.
module router_fifo #(
  parameter int unsigned WIDTH = 22,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             ready,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] CountFull = (PtrW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             do_push, do_pop;

  assign full    = reset && (count_q == CountFull);
  assign empty   = !reset || (count_q == '0);
  assign ready   = reset && (count_q != CountFull);
  assign do_push = push && ready;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop) begin
        count_q <= count_q + 1'b1;
      end else if (do_pop && !do_push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/param_leaf_router.sv
// Leaf router: GPU traffic fans out to spines by address; local traffic is round-robin
// arbitrated onto the single GPU egress, non-local spine arrivals are dropped and counted.
module param_leaf_router
  import leaf_router_pkg::*;
#(
  parameter int unsigned N_SPINE    = 4,
  parameter int unsigned DWIDTH     = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [1:0]  ROUTER_ID  = 2'd2,
  parameter logic [3:0]  GROUP_ID   = 4'b0110
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                arb_enable,
  param_leaf_router_if.router bus,
  output logic [N_SPINE-1:0]  spine_fifo_full,
  output logic [N_SPINE-1:0]  spine_fifo_empty,
  output logic                gpu_fifo_full,
  output logic                gpu_fifo_empty,
  output logic [2:0]          current_grant,
  output logic                busy,
  output logic [7:0]          drop_count
);

  localparam int unsigned EntW = DWIDTH + ADDR_W;
  localparam int unsigned NReq = N_SPINE + 1;
  localparam int unsigned SelW = (N_SPINE > 2) ? $clog2(N_SPINE) : 1;
  localparam logic [2:0]  GpuReq = 3'(N_SPINE);

  logic [EntW-1:0]    gpu_head;
  logic               gpu_pop;
  logic [EntW-1:0]    spine_head [N_SPINE];
  logic [N_SPINE-1:0] spine_pop;
  logic [N_SPINE-1:0] spine_ready;

  router_fifo #(.WIDTH(EntW), .DEPTH(FIFO_DEPTH)) u_gpu_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (bus.gpu_in_valid),
    .push_data ({bus.gpu_dest_addr, bus.gpu_in_data}),
    .ready     (bus.gpu_in_ready),
    .pop       (gpu_pop),
    .head      (gpu_head),
    .full      (gpu_fifo_full),
    .empty     (gpu_fifo_empty)
  );

  for (genvar k = 0; k < N_SPINE; k++) begin : g_spine_fifo
    router_fifo #(.WIDTH(EntW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (bus.spine_in_valid[k]),
      .push_data ({bus.spine_dest_addr[k*ADDR_W +: ADDR_W], bus.spine_in_data[k*DWIDTH +: DWIDTH]}),
      .ready     (spine_ready[k]),
      .pop       (spine_pop[k]),
      .head      (spine_head[k]),
      .full      (spine_fifo_full[k]),
      .empty     (spine_fifo_empty[k])
    );
  end

  assign bus.spine_in_ready = spine_ready;

  // GPU -> spine forwarding
  logic               gpu_head_local;
  logic [SelW-1:0]    gpu_dst;
  logic               gpu_fwd;
  logic [N_SPINE-1:0] sp_valid_q;
  logic [EntW-1:0]    sp_ent_q [N_SPINE];
  logic [N_SPINE-1:0] sp_load;

  assign gpu_head_local = is_local_addr(gpu_head[EntW-1 -: ADDR_W], GROUP_ID, ROUTER_ID);
  assign gpu_dst        = gpu_head[DWIDTH +: SelW];

  always_comb begin
    sp_load = '0;
    gpu_fwd = arb_enable && !gpu_fifo_empty && !gpu_head_local &&
              (!sp_valid_q[gpu_dst] || bus.spine_out_ready[gpu_dst]);
    if (gpu_fwd) sp_load[gpu_dst] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sp_valid_q <= '0;
    end else begin
      for (int k = 0; k < N_SPINE; k++) begin
        if (sp_load[k]) begin
          sp_valid_q[k] <= 1'b1;
          sp_ent_q[k]   <= gpu_head;
        end else if (bus.spine_out_ready[k]) begin
          sp_valid_q[k] <= 1'b0;
        end
      end
    end
  end

  logic [N_SPINE*DWIDTH-1:0] sp_out_data;
  logic [N_SPINE*ADDR_W-1:0] sp_out_addr;

  always_comb begin
    sp_out_data = '0;
    sp_out_addr = '0;
    for (int k = 0; k < N_SPINE; k++) begin
      sp_out_data[k*DWIDTH +: DWIDTH] = sp_ent_q[k][DWIDTH-1:0];
      sp_out_addr[k*ADDR_W +: ADDR_W] = sp_ent_q[k][EntW-1 -: ADDR_W];
    end
  end

  assign bus.spine_out_data      = sp_out_data;
  assign bus.spine_out_dest_addr = sp_out_addr;
  assign bus.spine_out_valid     = sp_valid_q;

  // Requests for GPU egress and spine drops
  logic [NReq-1:0]    req;
  logic [N_SPINE-1:0] drop;

  always_comb begin
    req  = '0;
    drop = '0;
    for (int k = 0; k < N_SPINE; k++) begin
      if (!spine_fifo_empty[k]) begin
        if (is_local_addr(spine_head[k][EntW-1 -: ADDR_W], GROUP_ID, ROUTER_ID)) begin
          req[k] = 1'b1;
        end else begin
          drop[k] = arb_enable;
        end
      end
    end
    req[N_SPINE] = !gpu_fifo_empty && gpu_head_local;
  end

  arb_state_e        state_q, state_d;
  logic [2:0]        last_q, last_d, grant_q, grant_d;
  logic [2:0]        base, pick;
  logic              pick_found, arb_load;
  logic [EntW-1:0]   pick_ent;
  logic              out_valid_q, out_valid_d;
  logic [DWIDTH-1:0] out_data_q, out_data_d;
  logic [7:0]        drop_q, drop_d;
  logic [8:0]        drop_sum;
  int unsigned       idx;

  // In HOLD the current grant becomes last_grant on completion, so search after it.
  always_comb begin
    pick       = GRANT_NONE;
    pick_found = 1'b0;
    idx        = 0;
    base       = (state_q == StHold) ? grant_q : last_q;
    for (int unsigned i = 1; i <= NReq; i++) begin
      idx = (32'(base) + i) % NReq;
      if (!pick_found && req[idx]) begin
        pick_found = 1'b1;
        pick       = 3'(idx);
      end
    end
    pick_ent = gpu_head;
    for (int k = 0; k < N_SPINE; k++) begin
      if (pick == 3'(k)) pick_ent = spine_head[k];
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    grant_d     = grant_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    arb_load    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (arb_enable && pick_found) begin
          arb_load = 1'b1;
          state_d  = StHold;
        end
      end
      StHold: begin
        if (out_valid_q && bus.gpu_out_ready) begin
          last_d = grant_q;
          if (arb_enable && pick_found) begin
            arb_load = 1'b1;
          end else begin
            state_d     = StIdle;
            out_valid_d = 1'b0;
            grant_d     = GRANT_NONE;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (arb_load) begin
      out_valid_d = 1'b1;
      out_data_d  = pick_ent[DWIDTH-1:0];
      grant_d     = pick;
    end
  end

  always_comb begin
    gpu_pop = gpu_fwd || (arb_load && (pick == GpuReq));
    for (int k = 0; k < N_SPINE; k++) begin
      spine_pop[k] = drop[k] || (arb_load && (pick == 3'(k)));
    end
    drop_sum = {1'b0, drop_q};
    for (int k = 0; k < N_SPINE; k++) begin
      drop_sum = drop_sum + 9'(drop[k]);
    end
    drop_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      last_q      <= GpuReq;
      grant_q     <= GRANT_NONE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      grant_q     <= grant_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      drop_q      <= drop_d;
    end
  end

  assign bus.gpu_out_valid = out_valid_q;
  assign bus.gpu_out_data  = out_data_q;
  assign current_grant     = (state_q == StHold) ? grant_q : GRANT_NONE;
  assign busy              = reset && ((state_q == StHold) || out_valid_q || (|sp_valid_q));
  assign drop_count        = drop_q;

endmodule

// File: tb/tb_param_leaf_router.sv
// Randomised and directed scoreboard bench for param_leaf_router (N_SPINE=4, DWIDTH=16).
module tb_param_leaf_router;

  localparam int unsigned NS = 4;
  localparam int unsigned DW = 16;
  localparam logic [5:0] LOCAL_ADDR = 6'b011010;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic arb_enable = 1'b1;
  always #5 clk = ~clk;

  param_leaf_router_if #(.N_SPINE(NS), .DWIDTH(DW)) bus_if ();

  logic [NS-1:0] spine_fifo_full, spine_fifo_empty;
  logic          gpu_fifo_full, gpu_fifo_empty;
  logic [2:0]    current_grant;
  logic          busy;
  logic [7:0]    drop_count;

  param_leaf_router #(.N_SPINE(NS), .DWIDTH(DW), .FIFO_DEPTH(8), .ROUTER_ID(2'd2),
                      .GROUP_ID(4'b0110)) dut (
    .clk              (clk),
    .reset            (rst_n),
    .arb_enable       (arb_enable),
    .bus              (bus_if.router),
    .spine_fifo_full  (spine_fifo_full),
    .spine_fifo_empty (spine_fifo_empty),
    .gpu_fifo_full    (gpu_fifo_full),
    .gpu_fifo_empty   (gpu_fifo_empty),
    .current_grant    (current_grant),
    .busy             (busy),
    .drop_count       (drop_count)
  );

  // Port 4 is the GPU ingress, ports 0..3 the spines.
  logic [4:0]       in_valid = '0;
  logic [4:0][15:0] in_data = '0;
  logic [4:0][5:0]  in_addr = '0;
  logic             gpu_out_ready = 1'b1;
  logic [3:0]       sp_out_ready = 4'hF;

  assign bus_if.gpu_in_valid    = in_valid[4];
  assign bus_if.gpu_in_data     = in_data[4];
  assign bus_if.gpu_dest_addr   = in_addr[4];
  assign bus_if.spine_in_valid  = in_valid[3:0];
  assign bus_if.spine_in_data   = in_data[3:0];
  assign bus_if.spine_dest_addr = in_addr[3:0];
  assign bus_if.gpu_out_ready   = gpu_out_ready;
  assign bus_if.spine_out_ready = sp_out_ready;

  logic [21:0] stim_q [5][$];
  logic [15:0] gexp_q [5][$];
  logic [21:0] sexp_q [4][$];
  int          grant_log [$];
  int          exp_drops = 0;
  int          total = 0;
  int          bad = 0;
  int          seq = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic port_ready(input int p);
    if (p == 4) return bus_if.gpu_in_ready;
    return bus_if.spine_in_ready[p];
  endfunction

  // Reference routing: local words go to GPU egress per source, GPU non-local to the
  // spine named by addr[1:0], spine non-local words vanish and count as drops.
  task automatic model_accept(input int p, input logic [5:0] a, input logic [15:0] d);
    if (a == LOCAL_ADDR) gexp_q[p].push_back(d);
    else if (p == 4) sexp_q[a[1:0]].push_back({a, d});
    else exp_drops++;
  endtask

  task automatic push_stim(input int p, input logic [5:0] a);
    stim_q[p].push_back({a, 3'(p), 13'(seq)});
    seq++;
  endtask

  function automatic bit idle();
    bit r = (in_valid == '0);
    for (int p = 0; p < 5; p++) if (stim_q[p].size() != 0 || gexp_q[p].size() != 0) r = 0;
    for (int k = 0; k < 4; k++) if (sexp_q[k].size() != 0) r = 0;
    return r;
  endfunction

  initial begin : driver
    logic [4:0]  acc;
    logic [21:0] e;
    forever begin
      @(negedge clk);
      for (int p = 0; p < 5; p++) begin
        acc[p] = in_valid[p] && port_ready(p);
        if (acc[p]) model_accept(p, in_addr[p], in_data[p]);
      end
      @(posedge clk);
      #1;
      for (int p = 0; p < 5; p++) begin
        if (acc[p] || !in_valid[p]) begin
          if (stim_q[p].size() > 0) begin
            e = stim_q[p].pop_front();
            in_valid[p] = 1'b1;
            in_addr[p]  = e[21:16];
            in_data[p]  = e[15:0];
          end else begin
            in_valid[p] = 1'b0;
          end
        end
      end
    end
  end

  initial begin : monitor
    int src;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus_if.gpu_out_valid && gpu_out_ready) begin
          src = int'(bus_if.gpu_out_data[15:13]);
          if (src > 4 || gexp_q[src].size() == 0) begin
            total++;
            bad++;
            $display("FAIL gpu_unexpected: got %0h expected no output", bus_if.gpu_out_data);
          end else begin
            check("gpu_data", 32'(bus_if.gpu_out_data), 32'(gexp_q[src].pop_front()));
            check("gpu_grant", 32'(current_grant), 32'(src));
            grant_log.push_back(int'(current_grant));
          end
        end
        for (int k = 0; k < 4; k++) begin
          if (bus_if.spine_out_valid[k] && sp_out_ready[k]) begin
            if (sexp_q[k].size() == 0) begin
              total++;
              bad++;
              $display("FAIL spine_unexpected: port %0d got %0h expected no output", k,
                       bus_if.spine_out_data[k*16 +: 16]);
            end else begin
              check("spine_data", 32'({bus_if.spine_out_dest_addr[k*6 +: 6],
                                       bus_if.spine_out_data[k*16 +: 16]}),
                    32'(sexp_q[k].pop_front()));
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit");
  end

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    for (int p = 0; p < 5; p++) gexp_q[p].delete();
    for (int k = 0; k < 4; k++) sexp_q[k].delete();
    grant_log.delete();
    exp_drops = 0;
    @(negedge clk);
    check("rst_in_ready", 32'({bus_if.gpu_in_ready, bus_if.spine_in_ready}), 32'h0);
    check("rst_empty", 32'({gpu_fifo_empty, spine_fifo_empty}), 32'h1F);
    check("rst_full", 32'({gpu_fifo_full, spine_fifo_full}), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_grant", 32'(current_grant), 32'h7);
    check("post_rst_drops", 32'(drop_count), 32'h0);
    check("post_rst_valid", 32'({bus_if.gpu_out_valid, bus_if.spine_out_valid}), 32'h0);
    check("post_rst_empty", 32'({gpu_fifo_empty, spine_fifo_empty}), 32'h1F);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (!idle() && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check(name, 32'(idle()), 32'h1);
  endtask

  task automatic wait_port_done(input int p);
    int n = 0;
    while ((stim_q[p].size() != 0 || in_valid[p]) && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin : main
    int n;
    int exp_sat;
    logic [5:0] a;
    int p;

    do_reset();

    // GPU to spine 3, two-edge latency
    stim_q[4].push_back({6'b011011, 16'hA5A5});
    n = 0;
    while (!(in_valid[4] && bus_if.gpu_in_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("lat_early", 32'(bus_if.spine_out_valid), 32'h0);
    @(negedge clk);
    check("lat_valid", 32'(bus_if.spine_out_valid), 32'h8);
    check("lat_data", 32'(bus_if.spine_out_data[63:48]), 32'hA5A5);
    check("lat_addr", 32'(bus_if.spine_out_dest_addr[23:18]), 32'h1B);
    drain("drain_fwd");

    // Four spines simultaneously local: grants 0,1,2,3
    do_reset();
    for (int k = 0; k < 4; k++) push_stim(k, LOCAL_ADDR);
    drain("drain_rr");
    check("rr_count", 32'(grant_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++) check("rr_order", 32'(grant_log[i]), 32'(i));

    // Loopback and spine 0 alternate
    do_reset();
    for (int i = 0; i < 3; i++) begin
      push_stim(4, LOCAL_ADDR);
      push_stim(0, LOCAL_ADDR);
    end
    drain("drain_alt");
    check("alt_count", 32'(grant_log.size()), 32'd6);
    for (int i = 0; i < 6 && i < grant_log.size(); i++)
      check("alt_order", 32'(grant_log[i]), (i % 2 == 0) ? 32'd0 : 32'd4);

    // Backpressure fills spine 1 FIFO and holds egress stable
    do_reset();
    gpu_out_ready = 1'b0;
    for (int i = 0; i < 9; i++) push_stim(1, LOCAL_ADDR);
    wait_port_done(1);
    @(negedge clk);
    check("bp_full", 32'(spine_fifo_full[1]), 32'h1);
    check("bp_ready", 32'(bus_if.spine_in_ready[1]), 32'h0);
    for (int i = 0; i < 3; i++) begin
      check("bp_valid", 32'(bus_if.gpu_out_valid), 32'h1);
      check("bp_hold", 32'(bus_if.gpu_out_data), (gexp_q[1].size() > 0) ? 32'(gexp_q[1][0]) : 32'hDEAD);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    gpu_out_ready = 1'b1;
    drain("drain_bp");

    // Wrong-group spine traffic is dropped
    do_reset();
    for (int i = 0; i < 3; i++) push_stim(2, 6'b010010);
    drain("drain_drop");
    check("drop_count", 32'(drop_count), 32'd3);

    // Reset while holding a word on GPU egress
    do_reset();
    gpu_out_ready = 1'b0;
    push_stim(0, LOCAL_ADDR);
    push_stim(0, LOCAL_ADDR);
    wait_port_done(0);
    @(negedge clk);
    check("hold_busy", 32'(busy), 32'h1);
    check("hold_grant", 32'(current_grant), 32'h0);
    do_reset();
    @(posedge clk);
    #1;
    gpu_out_ready = 1'b1;
    drain("drain_after_rst");

    // Random traffic with random backpressure and arbitration gating
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk);
      #1;
      gpu_out_ready = ($urandom_range(0, 3) != 0);
      sp_out_ready  = 4'($urandom);
      arb_enable    = ($urandom_range(0, 4) != 0);
      if (c < 1200 && $urandom_range(0, 1) == 1) begin
        p = int'($urandom_range(0, 4));
        a = ($urandom_range(0, 1) == 1) ? LOCAL_ADDR : 6'($urandom);
        if (stim_q[p].size() < 4) push_stim(p, a);
      end
    end
    @(posedge clk);
    #1;
    gpu_out_ready = 1'b1;
    sp_out_ready  = 4'hF;
    arb_enable    = 1'b1;
    drain("drain_random");
    exp_sat = (exp_drops > 255) ? 255 : exp_drops;
    check("rand_drops", 32'(drop_count), 32'(exp_sat));
    check("rand_idle_grant", 32'(current_grant), 32'h7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
